jtdd_obj_dma: RTL and testbench

// - Sequences object-RAM access for the OBJ layer: on each VBLANK start, copies CPU object RAM (512x8) into a double-buffered shadow.
// - The object scanner reads only the last completed copy, so a frame never shows a half-updated sprite table.
// - Arbitrates the single CPU object-RAM port between the CPU and the copy engine.
// - Sits between CPU object RAM and the object line scanner's oram_addr/oram_data port.

---
 rtl/jtdd_obj_pkg.sv | 21 ++
 rtl/jtframe_dual_ram.sv | 33 +++
 rtl/jtdd_obj_dma.sv | 135 +++++++++++++
 tb/tb_jtdd_obj_dma.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_obj_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : jtdd_obj_pkg                                               |
// | Shared OBJ-layer definitions: copy engine state encoding and object  |
// | RAM geometry.                                                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package jtdd_obj_pkg;

  localparam int OBJ_ENTRY_BYTES = 5;
  localparam int OBJ_RAM_LEN     = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LT   = 2'd2,
    SWAP = 2'd3
  } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jtframe_dual_ram                                           |
// | Simple dual-port synchronous RAM: port A writes, port B reads with   |
// | one clock of latency.                                                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Port A: write only
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
  end

  // Port B: registered read
  always_ff @(posedge clk) begin
    q1 <= mem[addr1];
  end

endmodule
`default_nettype wire

// File: rtl/jtdd_obj_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : jtdd_obj_dma                                               |
// | Copies CPU object RAM into a double-buffered shadow on each VBLANK   |
// | start; the scanner always reads the last completed copy.             |
// | Optional macro: JTDD_OBJ_DMA_HALT_EN (halt the CPU during the copy). |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module jtdd_obj_dma
  import jtdd_obj_pkg::*;
#(
  parameter int AW  = 9,
  parameter int LEN = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vbl,
  input  logic          cpu_cs,
  input  logic [AW-1:0] cpu_addr,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dout,
  output logic          cpu_halt,
  input  logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);

  dma_state_t    state, state_nxt;
  logic [AW-1:0] dma_addr, dma_addr_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic          busy_nxt, done_nxt, abort_nxt;
  logic          vbl_l;
  logic          dma_we;
  logic          dma_stall;

`ifdef JTDD_OBJ_DMA_HALT_EN
  // CPU is held off for the whole copy, so its requests never delay the engine
  logic unused_cpu_cs;
  assign unused_cpu_cs = cpu_cs;
  assign dma_stall     = 1'b0;
  assign ram_addr      = busy ? dma_addr : cpu_addr;
  assign cpu_halt      = busy;
`else
  // CPU has priority on the shared port; the engine retries its read
  assign dma_stall = cpu_cs;
  assign ram_addr  = cpu_cs ? cpu_addr : dma_addr;
  assign cpu_halt  = 1'b0;
`endif

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dma_addr <= '0;
      wr_bank  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      vbl_l    <= 1'b0;
    end else begin
      state    <= state_nxt;
      dma_addr <= dma_addr_nxt;
      wr_bank  <= wr_bank_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      abort    <= abort_nxt;
      vbl_l    <= vbl;
    end
  end

  // Next-state logic; an early VBLANK end overrides every state
  always_comb begin
    state_nxt    = state;
    dma_addr_nxt = dma_addr;
    wr_bank_nxt  = wr_bank;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    dma_we       = 1'b0;
    if (busy && !vbl) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      abort_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (vbl && !vbl_l) begin
            state_nxt    = RD;
            dma_addr_nxt = '0;
            busy_nxt     = 1'b1;
          end
        end
        RD: begin
          if (!dma_stall) state_nxt = LT;
        end
        LT: begin
          dma_we = 1'b1;
          // Terminal test precedes the increment so dma_addr never wraps
          if (dma_addr == LAST_ADDR) begin
            state_nxt = SWAP;
          end else begin
            dma_addr_nxt = dma_addr + 1'b1;
            state_nxt    = RD;
          end
        end
        SWAP: begin
          wr_bank_nxt = ~wr_bank;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Banks always differ between writer and scanner, so no same-address hazard
  jtframe_dual_ram #(
    .DW (8),
    .AW (AW + 1)
  ) u_shadow (
    .clk   (clk),
    .data0 (ram_dout),
    .addr0 ({wr_bank, dma_addr}),
    .we0   (dma_we),
    .addr1 ({~wr_bank, obj_addr}),
    .q1    (obj_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_jtdd_obj_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_jtdd_obj_dma                                            |
// | Self-checking bench for the OBJ RAM copy engine.                     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_jtdd_obj_dma;

  localparam int AW  = 9;
  localparam int LEN = 512;

  logic          clk = 1'b0;
  logic          rst, vbl, cpu_cs;
  logic [AW-1:0] cpu_addr, ram_addr, obj_addr;
  logic [7:0]    ram_dout, obj_data;
  logic          cpu_halt, busy, done, abort;

  logic [7:0]    cpu_ram [0:LEN-1];
  logic [7:0]    sb_q [$];
  int            checks   = 0;
  int            failures = 0;

  int   n, halt_cycles, addr_bad, stall_writes;
  logic saw_done, saw_abort;

  jtdd_obj_dma #(.AW(AW), .LEN(LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .vbl      (vbl),
    .cpu_cs   (cpu_cs),
    .cpu_addr (cpu_addr),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .cpu_halt (cpu_halt),
    .obj_addr (obj_addr),
    .obj_data (obj_data),
    .busy     (busy),
    .done     (done),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  // CPU object RAM model: data valid one clock after the address
  always @(posedge clk) ram_dout <= cpu_ram[ram_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] key);
    for (int i = 0; i < LEN; i++) begin
      logic [8:0] a;
      a = 9'(i);
      cpu_ram[i] = a[7:0] ^ key;
    end
  endtask

  // Scanner read through the scoreboard: push on request, pop on data
  task automatic scan_check(input string tag, input int addr, input logic [7:0] key);
    logic [8:0] a;
    logic [7:0] exp;
    a = 9'(addr);
    exp = a[7:0] ^ key;
    obj_addr = a;
    sb_q.push_back(exp);
    tick();
    check(tag, 32'(obj_data), 32'(sb_q.pop_front()));
  endtask

  // Raise vbl and follow the copy; n counts clocks from the start edge
  task automatic run_frame(input int stall_at, input int stop_at, input bit toggle);
    int exp_a, nxt_a;
    vbl = 1'b1;
    n = -1;
    saw_done = 1'b0; saw_abort = 1'b0;
    halt_cycles = 0; addr_bad = 0; stall_writes = 0;
    while (n < 3000 && !saw_done && !saw_abort && (stop_at < 0 || n < stop_at)) begin
      @(posedge clk); #1;
      n++;
      exp_a = (n < 2*LEN) ? n/2 : LEN-1;
      if (cpu_halt) halt_cycles++;
      if (toggle && busy && (ram_addr != AW'(exp_a) || ram_addr == cpu_addr)) addr_bad++;
      if (cpu_cs && dut.dma_we) stall_writes++;
      if (done)  saw_done  = 1'b1;
      if (abort) saw_abort = 1'b1;
      if (toggle) begin
        nxt_a    = (n + 1 < 2*LEN) ? (n + 1)/2 : LEN-1;
        cpu_cs   = ~cpu_cs;
        cpu_addr = ~AW'(nxt_a);
      end else if (stall_at >= 0 && n >= stall_at && n < stall_at + 10) begin
        cpu_cs   = 1'b1;
        cpu_addr = 9'd7;
      end else begin
        cpu_cs   = 1'b0;
      end
    end
    cpu_cs = 1'b0;
  endtask

  task automatic end_frame();
    vbl = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; vbl = 1'b0; cpu_cs = 1'b0; cpu_addr = '0; obj_addr = '0;
    fill(8'h5A);
    repeat (3) tick();
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_halt",  32'(cpu_halt), 0);
    check("rst_bank",  32'(dut.wr_bank), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Frame 1: plain copy
    run_frame(-1, -1, 1'b0);
    check("f1_done", 32'(saw_done), 1);
    check("f1_lat",  32'(n), 1025);
`ifdef JTDD_OBJ_DMA_HALT_EN
    check("f1_halt", 32'(halt_cycles), 1025);
`else
    check("f1_halt", 32'(halt_cycles), 0);
`endif
    check("f1_bank", 32'(dut.wr_bank), 1);
    end_frame();
    scan_check("f1_1ff", 9'h1FF, 8'h5A);
    scan_check("f1_000", 0, 8'h5A);
    scan_check("f1_100", 100, 8'h5A);

    // Frame 2: vbl falls at dma_addr=200
    fill(8'h3C);
    run_frame(-1, 400, 1'b0);
    vbl = 1'b0;
    tick();
    check("ab_pulse", 32'(abort), 1);
    check("ab_done",  32'(done | saw_done), 0);
    check("ab_busy",  32'(busy), 0);
    tick();
    check("ab_width", 32'(abort), 0);
    check("ab_bank",  32'(dut.wr_bank), 1);
    scan_check("ab_1ff", 9'h1FF, 8'h5A);
    scan_check("ab_010", 16, 8'h5A);

    // Reset mid-copy at dma_addr=50, then a full copy
    fill(8'h96);
    run_frame(-1, 100, 1'b0);
    rst = 1'b1; vbl = 1'b0;
    tick(); tick();
    check("rs_busy",  32'(busy), 0);
    check("rs_bank",  32'(dut.wr_bank), 0);
    check("rs_abort", 32'(abort), 0);
    rst = 1'b0;
    repeat (2) tick();
    run_frame(-1, -1, 1'b0);
    check("rs_lat", 32'(n), 1025);
    end_frame();
    scan_check("rs_000", 0, 8'h96);
    scan_check("rs_1ff", 9'h1FF, 8'h96);

    // CPU access for 10 clocks at dma_addr=100
    fill(8'hC3);
    run_frame(200, -1, 1'b0);
`ifdef JTDD_OBJ_DMA_HALT_EN
    check("st_lat", 32'(n), 1025);
`else
    check("st_lat", 32'(n), 1035);
    check("st_wr",  32'(stall_writes), 0);
`endif
    end_frame();
    scan_check("st_100", 100, 8'hC3);
    scan_check("st_101", 101, 8'hC3);

    // Three consecutive frames from reset: bank 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("tf_bank0", 32'(dut.wr_bank), 0);
    for (int f = 0; f < 3; f++) begin
      logic [7:0] key;
      key = 8'(8'h11 * (f + 1));
      fill(key);
      run_frame(-1, -1, 1'b0);
      check("tf_lat",  32'(n), 1025);
      check("tf_bank", 32'(dut.wr_bank), 32'((f % 2) == 0));
      end_frame();
      scan_check("tf_007", 7, key);
      scan_check("tf_1fe", 9'h1FE, key);
    end

`ifdef JTDD_OBJ_DMA_HALT_EN
    // CPU toggling every clock is held off for the whole copy
    fill(8'hE7);
    run_frame(-1, -1, 1'b1);
    check("ht_lat",  32'(n), 1025);
    check("ht_halt", 32'(halt_cycles), 1025);
    check("ht_addr", 32'(addr_bad), 0);
    end_frame();
    scan_check("ht_055", 85, 8'hE7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
